// File: rtl/line_fetch_ctrl.sv
// Scanline fetch scheduler: prefetches the next visible line into a ping-pong buffer and streams pixels.
// Optional `UNDERRUN_CNT_EN adds a saturating 16-bit underrun_cnt output.
module line_fetch_ctrl #(
    parameter int               H_ACTIVE   = 640,
    parameter int               V_ACTIVE   = 480,
    parameter int               V_TOTAL    = 525,
    parameter int               ADDR_W     = 24,
    parameter int               PIX_W      = 16,
    parameter int               BURST      = 16,
    parameter logic [PIX_W-1:0] FILL_COLOR = '0
) (
    input  logic              clk_pix,
    input  logic              resetn,
    input  logic [9:0]        x,
    input  logic [9:0]        y,
    input  logic              active,
    input  logic [ADDR_W-1:0] fb_base,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [PIX_W-1:0]  mem_rdata,
    output logic [PIX_W-1:0]  pix_data,
    output logic              underrun
`ifdef UNDERRUN_CNT_EN
    ,
    output logic [15:0]       underrun_cnt
`endif
);

    localparam int CNT_W = $clog2(H_ACTIVE + 1);
    localparam int X_W   = $clog2(H_ACTIVE);

    typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT} state_t;

    state_t              state_q;
    logic                mem_req_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [ADDR_W-1:0]   line_addr_q;
    logic [CNT_W-1:0]    req_cnt_q;
    logic [CNT_W-1:0]    rcv_cnt_q;
    logic [1:0]          valid_q;
    logic [1:0]          valid_d;
    logic                bank_q;
    logic                underrun_q;
    logic                line_ok_q;
    logic [PIX_W-1:0]    pix_data_q;
    logic [PIX_W-1:0]    line_buf [2][H_ACTIVE];

    logic                trig_frame;
    logic                trig_line;
    logic                trig;
    logic                tgt_bank;
    logic                busy;
    logic                accept;
    logic                beat;
    logic                last_beat;
    logic                last_req;
    logic [ADDR_W-1:0]   next_line_addr;
    logic [CNT_W-1:0]    req_cnt_inc;
    logic                line_ok_cur;
    logic [X_W-1:0]      rd_idx;
    logic [PIX_W-1:0]    rd_pix;

    assign trig_frame     = (x == 10'd0) && (y == 10'(V_TOTAL - 1));
    assign trig_line      = (x == 10'd0) && (y < 10'(V_ACTIVE - 1));
    assign trig           = trig_frame | trig_line;
    assign tgt_bank       = trig_frame ? 1'b0 : ~y[0];
    assign next_line_addr = trig_frame ? fb_base : line_addr_q + ADDR_W'(H_ACTIVE);
    assign busy           = (state_q != ST_IDLE);
    assign accept         = (state_q == ST_REQ) && mem_req_q && mem_gnt;
    assign beat           = busy && mem_rvalid;
    assign last_beat      = beat && (rcv_cnt_q == CNT_W'(H_ACTIVE - 1));
    assign req_cnt_inc    = req_cnt_q + CNT_W'(BURST);
    assign last_req       = (req_cnt_inc == CNT_W'(H_ACTIVE));

    // A trigger always invalidates its target bank, even when dropped, so stale data is never shown.
    always_comb begin
        valid_d = valid_q;
        if (last_beat) valid_d[bank_q] = 1'b1;
        if (trig)      valid_d[tgt_bank] = 1'b0;
    end

    always_ff @(posedge clk_pix or negedge resetn) begin
        if (!resetn) begin
            state_q     <= ST_IDLE;
            mem_req_q   <= 1'b0;
            mem_addr_q  <= '0;
            line_addr_q <= '0;
            req_cnt_q   <= '0;
            rcv_cnt_q   <= '0;
            valid_q     <= '0;
            bank_q      <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            underrun_q <= trig && busy;
            valid_q    <= valid_d;
            if (trig) line_addr_q <= next_line_addr;
            case (state_q)
                ST_IDLE: begin
                    if (trig) begin
                        state_q    <= ST_REQ;
                        bank_q     <= tgt_bank;
                        req_cnt_q  <= '0;
                        rcv_cnt_q  <= '0;
                        mem_req_q  <= 1'b1;
                        mem_addr_q <= next_line_addr;
                    end
                end
                ST_REQ, ST_WAIT: begin
                    if (beat) rcv_cnt_q <= rcv_cnt_q + CNT_W'(1);
                    if (accept) begin
                        req_cnt_q  <= req_cnt_inc;
                        mem_addr_q <= mem_addr_q + ADDR_W'(BURST);
                        if (last_req) begin
                            mem_req_q <= 1'b0;
                            state_q   <= ST_WAIT;
                        end
                    end
                    if (last_beat) begin
                        mem_req_q <= 1'b0;
                        state_q   <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_pix) begin
        if (beat) line_buf[bank_q][rcv_cnt_q[X_W-1:0]] <= mem_rdata;
    end

    // Line validity is frozen at x==0 so a line is never half fill, half data.
    assign line_ok_cur = (x == 10'd0) ? valid_q[y[0]] : line_ok_q;
    assign rd_idx      = (x < 10'(H_ACTIVE)) ? x[X_W-1:0] : '0;
    assign rd_pix      = line_buf[y[0]][rd_idx];

    always_ff @(posedge clk_pix or negedge resetn) begin
        if (!resetn) begin
            line_ok_q  <= 1'b0;
            pix_data_q <= '0;
        end else begin
            if (x == 10'd0) line_ok_q <= valid_q[y[0]];
            if (!active)          pix_data_q <= '0;
            else if (line_ok_cur) pix_data_q <= rd_pix;
            else                  pix_data_q <= FILL_COLOR;
        end
    end

`ifdef UNDERRUN_CNT_EN
    logic [15:0] underrun_cnt_q;

    always_ff @(posedge clk_pix or negedge resetn) begin
        if (!resetn) begin
            underrun_cnt_q <= '0;
        end else if (underrun_q && (underrun_cnt_q != 16'hFFFF)) begin
            underrun_cnt_q <= underrun_cnt_q + 16'd1;
        end
    end

    assign underrun_cnt = underrun_cnt_q;
`endif

    assign mem_req  = mem_req_q;
    assign mem_addr = mem_addr_q;
    assign pix_data = pix_data_q;
    assign underrun = underrun_q;

endmodule

// File: tb/tb_line_fetch_ctrl.sv
// Directed bench for line_fetch_ctrl using a shrunk video timing (48x15 total, 32x12 visible).
// Memory returns the low 16 bits of each word address as data.
module tb_line_fetch_ctrl;

    localparam int          H_ACTIVE = 32;
    localparam int          H_TOTAL  = 48;
    localparam int          V_ACTIVE = 12;
    localparam int          V_TOTAL  = 15;
    localparam int          BURST    = 8;
    localparam logic [15:0] FILL     = 16'hDEAD;

    logic        clk_pix = 1'b0;
    logic        resetn;
    logic [9:0]  x;
    logic [9:0]  y;
    logic        active;
    logic [23:0] fb_base;
    logic        mem_req;
    logic [23:0] mem_addr;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [15:0] mem_rdata;
    logic [15:0] pix_data;
    logic        underrun;
`ifdef UNDERRUN_CNT_EN
    logic [15:0] underrun_cnt;
`endif

    always #5 clk_pix = ~clk_pix;

    line_fetch_ctrl #(
        .H_ACTIVE(H_ACTIVE), .V_ACTIVE(V_ACTIVE), .V_TOTAL(V_TOTAL),
        .ADDR_W(24), .PIX_W(16), .BURST(BURST), .FILL_COLOR(FILL)
    ) dut (
        .clk_pix(clk_pix), .resetn(resetn), .x(x), .y(y), .active(active),
        .fb_base(fb_base), .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .pix_data(pix_data),
        .underrun(underrun)
`ifdef UNDERRUN_CNT_EN
        , .underrun_cnt(underrun_cnt)
`endif
    );

    int          checks = 0;
    int          errors = 0;
    int          gnt_delay = 0;
    int          wait_cnt = 0;
    bit          stall = 1'b0;
    logic [23:0] beat_q[$];
    logic [23:0] acc_log[$];
    int          acc_y[$];
    int          last_x = -1;
    int          last_y = -1;
    int          ur_count = 0;
    int          ur_x = -1;
    int          ur_y = -1;
    int          hold_viol = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: account for what the DUT consumed at the edge, then drive the next inputs.
    task automatic step();
        logic        req_b;
        logic        gnt_b;
        logic        rv_b;
        logic [23:0] addr_b;
        int          px;
        int          py;
        req_b  = mem_req;
        gnt_b  = mem_gnt;
        rv_b   = mem_rvalid;
        addr_b = mem_addr;
        px     = int'(x);
        py     = int'(y);
        @(posedge clk_pix);
        #1;
        last_x = px;
        last_y = py;
        if (rv_b && beat_q.size() > 0) void'(beat_q.pop_front());
        if (req_b && gnt_b) begin
            for (int i = 0; i < BURST; i++) beat_q.push_back(addr_b + 24'(i));
            acc_log.push_back(addr_b);
            acc_y.push_back(py);
            wait_cnt = 0;
        end else if (req_b) begin
            wait_cnt++;
            if (resetn && mem_req && (mem_addr !== addr_b)) hold_viol++;
        end
        if (underrun === 1'b1) begin
            ur_count++;
            ur_x = last_x;
            ur_y = last_y;
        end
        if (int'(x) == H_TOTAL - 1) begin
            x = 10'd0;
            y = (int'(y) == V_TOTAL - 1) ? 10'd0 : y + 10'd1;
        end else begin
            x = x + 10'd1;
        end
        active     = (int'(x) < H_ACTIVE) && (int'(y) < V_ACTIVE);
        mem_gnt    = mem_req && (wait_cnt >= gnt_delay);
        mem_rvalid = !stall && (beat_q.size() > 0);
        mem_rdata  = mem_rvalid ? beat_q[0][15:0] : 16'h0000;
    endtask

    task automatic run_to(input int tx, input int ty);
        int n;
        n = 0;
        while (!(last_x == tx && last_y == ty) && n < 2000) begin
            step();
            n++;
        end
        if (!(last_x == tx && last_y == ty)) begin
            checks++;
            errors++;
            $error("FAIL run_to_%0d_%0d observed=timeout expected=reached", tx, ty);
        end
    endtask

    initial begin
        int n;
        resetn     = 1'b0;
        x          = 10'd40;
        y          = 10'd13;
        active     = 1'b0;
        fb_base    = 24'h000000;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = 16'h0000;

        step();
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_pix_data", 32'(pix_data), 32'd0);
        check("rst_underrun", 32'(underrun), 32'd0);
        step();
        step();
        resetn    = 1'b1;
        gnt_delay = 3;

        // Frame prefetch at y=14 gets one burst accepted, then reset hits mid-REQ.
        n = 0;
        while (acc_log.size() == 0 && n < 200) begin
            step();
            n++;
        end
        check("abort_first_accept", 32'(acc_log.size()), 32'd1);
        resetn = 1'b0;
        #1;
        check("abort_mem_req", 32'(mem_req), 32'd0);
        step();
        step();
        step();
        check("abort_pix_data", 32'(pix_data), 32'd0);
        resetn    = 1'b1;
        gnt_delay = 0;
        run_to(2, 0);
        check("abort_line0_fill", 32'(pix_data), 32'(FILL));
        run_to(3, 1);
        check("abort_line1_pix", 32'(pix_data), 32'h0023);

        // Zero-wait frame from base 0x001000.
        fb_base = 24'h001000;
        run_to(47, 13);
        acc_log.delete();
        acc_y.delete();
        run_to(47, 14);
        check("l0_req_count", 32'(acc_log.size()), 32'd4);
        for (int i = 0; i < 4; i++) check("l0_req_addr", 32'(acc_log[i]), 32'h1000 + 32'(i * BURST));
        check("l0_req_row", 32'(acc_y[0]), 32'd14);
        run_to(0, 0);
        check("pix_x0_y0", 32'(pix_data), 32'h1000);
        run_to(5, 1);
        check("l1_req_addr", 32'(acc_log[4]), 32'h1020);
        check("pix_x5_y1", 32'(pix_data), 32'h1025);

        // Slow grants for line 3.
        run_to(47, 1);
        gnt_delay = 3;
        hold_viol = 0;
        run_to(31, 3);
        check("slow_gnt_hold", 32'(hold_viol), 32'd0);
        check("slow_gnt_pix", 32'(pix_data), 32'h107F);
        check("slow_gnt_no_ur", 32'(ur_count), 32'd0);
        gnt_delay = 0;

        // Beats for line 7 stall past the next line start.
        run_to(47, 5);
        stall = 1'b1;
        run_to(4, 7);
        check("stall_line7_fill", 32'(pix_data), 32'(FILL));
        run_to(10, 7);
        stall = 1'b0;
        check("stall_ur_count", 32'(ur_count), 32'd1);
        check("stall_ur_row", 32'(ur_y), 32'd7);
        check("stall_ur_col", 32'(ur_x), 32'd0);
        run_to(4, 8);
        check("stall_line8_fill", 32'(pix_data), 32'(FILL));
        run_to(4, 9);
        check("stall_line9_pix", 32'(pix_data), 32'h1124);
`ifdef UNDERRUN_CNT_EN
        check("ucnt_one", 32'(underrun_cnt), 32'd1);
`endif

        // New base mid-frame only takes effect at the next frame prefetch.
        run_to(0, 10);
        fb_base = 24'h002000;
        run_to(6, 11);
        check("base_hold_l11", 32'(pix_data), 32'h1166);
        run_to(6, 0);
        check("base_new_l0", 32'(pix_data), 32'h2006);
        run_to(6, 1);
        check("base_new_l1", 32'(pix_data), 32'h2026);

`ifdef UNDERRUN_CNT_EN
        run_to(47, 1);
        dut.underrun_cnt_q = 16'hFFFE;
        stall = 1'b1;
        run_to(10, 4);
        stall = 1'b0;
        run_to(47, 4);
        check("ucnt_total_pulses", 32'(ur_count), 32'd3);
        check("ucnt_saturate", 32'(underrun_cnt), 32'hFFFF);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
